// File: rtl/column_buffer_writer.sv
// Producer side of the double-buffered column wall RAM: accepts one ray per column,
// divides the projection constant by distance, and writes the packed word to the back bank.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a ray; also where a pending bank swap is taken
// DIV   | 16-cycle restoring divide HEIGHT_K / dist
// CLAMP | clamp quotient to MAX_HALF and launch the RAM write
// WRITE | wr_en high for this single cycle
module column_buffer_writer #(
  parameter int          NUM_COLS = 640,
  parameter logic [15:0] HEIGHT_K = 16'd15360,
  parameter logic [7:0]  MAX_HALF = 8'd240
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ray_valid,
  output logic        ray_ready,
  input  logic [9:0]  ray_col,
  input  logic [15:0] ray_dist,
  input  logic        ray_goal,
  input  logic [2:0]  ray_color,
  input  logic        frame_start,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        rd_bank,
  output logic [9:0]  col_count,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, DIV, CLAMP, WRITE} state_t;

  localparam logic [10:0] NUM_COLS_W = 11'(NUM_COLS);

  state_t      state;
  logic [9:0]  col_q;
  logic [15:0] dist_q;
  logic        goal_q;
  logic [2:0]  color_q;
  logic [15:0] rem_q;
  logic [15:0] quo_q;
  logic [3:0]  iter_cnt;
  logic        swap_pend;
  logic        init_done;

  logic        accept;
  logic [16:0] shifted_c;
  logic        fits_c;
  logic [15:0] diff_c;
  logic [7:0]  half_c;

  // Held low for the first cycle after reset so nothing is accepted during reset.
  assign ray_ready = (state == IDLE) && !swap_pend && init_done;
  assign accept    = ray_valid && ray_ready;

  // The remainder is always below dist, so the 16-bit difference is exact.
  always_comb begin
    shifted_c = {rem_q, quo_q[15]};
    fits_c    = shifted_c >= {1'b0, dist_q};
    diff_c    = shifted_c[15:0] - dist_q;
    half_c    = quo_q[7:0];
    if (quo_q > {8'd0, MAX_HALF})
      half_c = MAX_HALF;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      col_q     <= '0;
      dist_q    <= '0;
      goal_q    <= 1'b0;
      color_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      iter_cnt  <= '0;
      swap_pend <= 1'b0;
      init_done <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_bank   <= 1'b0;
      col_count <= '0;
      err       <= 1'b0;
    end else begin
      init_done <= 1'b1;

      // A pulse arriving on the swap edge itself is absorbed by that swap.
      if (state == IDLE && swap_pend) begin
        rd_bank   <= ~rd_bank;
        col_count <= '0;
        swap_pend <= 1'b0;
      end else if (frame_start) begin
        swap_pend <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          wr_en <= 1'b0;
          if (accept) begin
            col_q   <= ray_col;
            dist_q  <= ray_dist;
            goal_q  <= ray_goal;
            color_q <= ray_color;
            if ({1'b0, ray_col} >= NUM_COLS_W) begin
              err <= 1'b1;
            end else if (ray_dist == 16'd0) begin
              quo_q <= 16'hFFFF;
              state <= CLAMP;
            end else begin
              rem_q    <= '0;
              quo_q    <= HEIGHT_K;
              iter_cnt <= 4'd15;
              state    <= DIV;
            end
          end
        end
        DIV: begin
          rem_q <= fits_c ? diff_c : shifted_c[15:0];
          quo_q <= {quo_q[14:0], fits_c};
          if (iter_cnt == 4'd0)
            state <= CLAMP;
          else
            iter_cnt <= iter_cnt - 4'd1;
        end
        CLAMP: begin
          wr_en   <= 1'b1;
          wr_addr <= {~rd_bank, col_q};
          wr_data <= {color_q, goal_q, half_c};
          if (col_count != 10'h3FF)
            col_count <= col_count + 10'd1;
          state <= WRITE;
        end
        WRITE: begin
          wr_en <= 1'b0;
          state <= IDLE;
        end
        default: begin
          wr_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_column_buffer_writer.sv
// Directed bench for column_buffer_writer: hand-computed quotients, latency, bank swap,
// error handling, throughput, count saturation and mid-operation reset.
module tb_column_buffer_writer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ray_valid = 1'b0;
  logic        ray_ready;
  logic [9:0]  ray_col = '0;
  logic [15:0] ray_dist = '0;
  logic        ray_goal = 1'b0;
  logic [2:0]  ray_color = '0;
  logic        frame_start = 1'b0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [11:0] wr_data;
  logic        rd_bank;
  logic [9:0]  col_count;
  logic        err;

  int n_vec = 0;
  int n_miss = 0;

  column_buffer_writer dut (
    .Clk(Clk), .Reset(Reset),
    .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_col(ray_col), .ray_dist(ray_dist), .ray_goal(ray_goal), .ray_color(ray_color),
    .frame_start(frame_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_bank(rd_bank), .col_count(col_count), .err(err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  // Returns just after the accept edge.
  task automatic send_ray(input logic [9:0] c, input logic [15:0] d, input logic g,
                          input logic [2:0] colr);
    int guard;
    guard = 0;
    @(negedge Clk);
    while (!ray_ready && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    if (!ray_ready) chk("ready_timeout", 32'd0, 32'd1);
    ray_valid = 1'b1;
    ray_col   = c;
    ray_dist  = d;
    ray_goal  = g;
    ray_color = colr;
    @(posedge Clk);
    #1 ray_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until wr_en is seen; returns at the negedge of the write cycle.
  task automatic wait_write(output int edges);
    edges = 0;
    forever begin
      @(negedge Clk);
      if (wr_en || edges >= 40) break;
      @(posedge Clk);
      edges++;
    end
    if (!wr_en) chk("write_timeout", 32'd0, 32'd1);
  endtask

  int t_dist [7] = '{30, 0, 65535, 64, 65, 15360, 1};
  logic [7:0] t_half [7] = '{8'hF0, 8'hF0, 8'h00, 8'hF0, 8'hEC, 8'h01, 8'hF0};
  int t_lat [7] = '{17, 1, 17, 17, 17, 17, 17};

  initial begin
    int e;
    int nw;
    int nacc;
    int acc [4];
    logic [9:0] c;
    logic [2:0] colr;
    logic g;

    // reset state
    repeat (3) @(negedge Clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rd_bank", 32'(rd_bank), 32'd0);
    chk("rst_col_count", 32'(col_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(ray_ready), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("ready_after_rst", 32'(ray_ready), 32'd1);

    // basic ray: 15360/128 = 120 = 0x78; write sampled on the 18th edge after accept
    send_ray(10'd5, 16'd128, 1'b0, 3'b101);
    wait_write(e);
    chk("t1_latency", 32'(e), 32'd17);
    chk("t1_addr", 32'(wr_addr), 32'h405);
    chk("t1_data", 32'(wr_data), 32'hA78);
    chk("t1_count", 32'(col_count), 32'd1);
    @(negedge Clk);
    chk("t1_wr_en_single", 32'(wr_en), 32'd0);
    chk("t1_addr_hold", 32'(wr_addr), 32'h405);
    chk("t1_data_hold", 32'(wr_data), 32'hA78);

    // quotient / clamp table
    for (int i = 0; i < 7; i++) begin
      c = 10'(10 + i);
      g = i[0];
      colr = i[2:0];
      send_ray(c, t_dist[i][15:0], g, colr);
      wait_write(e);
      chk("t2_latency", 32'(e), 32'(t_lat[i]));
      chk("t2_addr", 32'(wr_addr), 32'({1'b1, c}));
      chk("t2_data", 32'(wr_data), 32'({colr, g, t_half[i]}));
    end
    chk("t2_count", 32'(col_count), 32'd8);

    // out-of-range column
    send_ray(10'd700, 16'd128, 1'b0, 3'b001);
    nw = 0;
    repeat (25) begin
      @(negedge Clk);
      if (wr_en) nw++;
    end
    chk("t3_no_write", 32'(nw), 32'd0);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_ready", 32'(ray_ready), 32'd1);
    send_ray(10'd639, 16'd128, 1'b1, 3'b010);
    wait_write(e);
    chk("t3_addr", 32'(wr_addr), 32'h67F);
    chk("t3_data", 32'(wr_data), 32'h578);
    chk("t3_count", 32'(col_count), 32'd9);
    chk("t3_err_sticky", 32'(err), 32'd1);

    // frame_start during DIV: ray finishes into bank 1, swap follows
    send_ray(10'd7, 16'd128, 1'b0, 3'b111);
    repeat (4) @(posedge Clk);
    @(negedge Clk) frame_start = 1'b1;
    @(negedge Clk) frame_start = 1'b0;
    wait_write(e);
    chk("t4_addr", 32'(wr_addr), 32'h407);
    chk("t4_data", 32'(wr_data), 32'hE78);
    chk("t4_bank_during_write", 32'(rd_bank), 32'd0);
    @(negedge Clk);
    chk("t4_ready_swap_cycle", 32'(ray_ready), 32'd0);
    chk("t4_bank_before_swap", 32'(rd_bank), 32'd0);
    @(negedge Clk);
    chk("t4_bank_after_swap", 32'(rd_bank), 32'd1);
    chk("t4_count_cleared", 32'(col_count), 32'd0);
    chk("t4_ready_after_swap", 32'(ray_ready), 32'd1);
    send_ray(10'd8, 16'd128, 1'b1, 3'b000);
    wait_write(e);
    chk("t4_next_addr", 32'(wr_addr), 32'h008);
    chk("t4_next_data", 32'(wr_data), 32'h178);

    // pulse in IDLE: swap on following edge, ray held off for that cycle
    @(negedge Clk) frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    ray_valid = 1'b1;
    ray_col = 10'd9;
    ray_dist = 16'd128;
    ray_goal = 1'b0;
    ray_color = 3'b011;
    chk("t4i_ready_low", 32'(ray_ready), 32'd0);
    @(posedge Clk);
    #1;
    chk("t4i_bank", 32'(rd_bank), 32'd0);
    chk("t4i_ready_high", 32'(ray_ready), 32'd1);
    @(posedge Clk);
    #1 ray_valid = 1'b0;
    wait_write(e);
    chk("t4i_latency", 32'(e), 32'd17);
    chk("t4i_addr", 32'(wr_addr), 32'h409);
    chk("t4i_data", 32'(wr_data), 32'h678);

    // back-to-back with valid held high
    @(negedge Clk);
    ray_valid = 1'b1;
    ray_col = 10'd20;
    ray_dist = 16'd128;
    ray_goal = 1'b0;
    ray_color = 3'b001;
    nacc = 0;
    nw = 0;
    for (int k = 0; k < 45; k++) begin
      if (ray_ready) begin
        if (nacc < 4) acc[nacc] = k;
        nacc++;
      end
      if (wr_en) nw++;
      @(negedge Clk);
    end
    ray_valid = 1'b0;
    chk("t5_accepts", 32'(nacc), 32'd3);
    chk("t5_spacing1", 32'(acc[1] - acc[0]), 32'd19);
    chk("t5_spacing2", 32'(acc[2] - acc[1]), 32'd19);
    chk("t5_writes", 32'(nw), 32'd2);
    repeat (30) @(negedge Clk);

    // col_count saturation using zero-distance rays
    ray_valid = 1'b1;
    ray_col = 10'd0;
    ray_dist = 16'd0;
    repeat (3100) @(negedge Clk);
    ray_valid = 1'b0;
    repeat (5) @(negedge Clk);
    chk("t5_count_sat", 32'(col_count), 32'h3FF);

    // two pulses during one ray: one swap only
    send_ray(10'd30, 16'd128, 1'b0, 3'b100);
    repeat (3) @(posedge Clk);
    @(negedge Clk) frame_start = 1'b1;
    @(negedge Clk) frame_start = 1'b0;
    repeat (4) @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk) frame_start = 1'b0;
    wait_write(e);
    chk("t5_pulse_addr", 32'(wr_addr), 32'h41E);
    repeat (10) @(negedge Clk);
    chk("t5_one_toggle", 32'(rd_bank), 32'd1);
    chk("t5_count_clr", 32'(col_count), 32'd0);

    // reset during DIV aborts
    send_ray(10'd3, 16'd128, 1'b0, 3'b110);
    repeat (9) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    chk("t6_wr_en", 32'(wr_en), 32'd0);
    chk("t6_wr_addr", 32'(wr_addr), 32'd0);
    chk("t6_wr_data", 32'(wr_data), 32'd0);
    chk("t6_rd_bank", 32'(rd_bank), 32'd0);
    chk("t6_col_count", 32'(col_count), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_ready", 32'(ray_ready), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    nw = 0;
    repeat (30) begin
      @(negedge Clk);
      if (wr_en) nw++;
    end
    chk("t6_no_write", 32'(nw), 32'd0);
    chk("t6_ready_back", 32'(ray_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/column_buffer_writer.md
Name: column_buffer_writer

Overview:
Producer side of the per-column wall buffer that the HDMI colour mapper reads as its 12-bit column word. Accepts one ray-cast result per screen column over a valid/ready handshake and converts distance to wall half-height with a serial divider. Writes the packed word into the back bank of a double-buffered column RAM. Swaps banks on the frame-start pulse so the display never reads a half-written frame.

Parameters:
NUM_COLS, 640, number of screen columns; legal ray_col range 0..NUM_COLS-1
HEIGHT_K, 16'd15360, projection constant; half_height = HEIGHT_K / ray_dist
MAX_HALF, 8'd240, clamp for half-height (equals screen vertical centre)

Ports:
Clk        input   1   system clock; all state changes on its rising edge
Reset      input   1   asynchronous, active-high reset
ray_valid  input   1   ray result presented
ray_ready  output  1   block can accept a ray this cycle
ray_col    input   10  screen column of the result
ray_dist   input   16  unsigned perpendicular wall distance
ray_goal   input   1   hit wall is the goal wall
ray_color  input   3   wall colour bits {B,G,R}
frame_start input  1   one-cycle pulse at start of vertical blank
wr_en      output  1   column RAM write strobe
wr_addr    output  11  {bank, column}
wr_data    output  12  {color[2:0], goal, half[7:0]}
rd_bank    output  1   bank the display side reads
col_count  output  10  columns written since last swap (saturates at 1023)
err        output  1   sticky: out-of-range column received

Behaviour:
- Reset (async, active-high): state IDLE, ray_ready 0 for the reset cycle then per rule below, wr_en 0, wr_addr 0, wr_data 0, rd_bank 0, col_count 0, swap_pend 0, err 0.
- ray_ready = (state==IDLE) && !swap_pend; combinational from registers only.
- FSM: IDLE -> DIV -> CLAMP -> WRITE -> IDLE.
  - IDLE: on ray_valid && ray_ready, latch col/dist/goal/color. If col >= NUM_COLS: set err, stay IDLE, no write. Else if dist==0: go to CLAMP with quotient forced to 16'hFFFF. Otherwise go to DIV.
  - DIV: 16-iteration restoring divide, HEIGHT_K / dist, one quotient bit per cycle, exactly 16 cycles.
  - CLAMP: half = (q > MAX_HALF) ? MAX_HALF : q[7:0]; 1 cycle.
  - WRITE: wr_en=1 for exactly one cycle; wr_addr={~rd_bank, col}; wr_data={color, goal, half}; col_count increments (saturating).
- Latency from the accept edge to the wr_en-high cycle:
  - Normal ray: 18 cycles.
  - dist==0: 2 cycles.
- Throughput: one ray per 19 cycles (3 for dist==0).
- wr_en is 0 in every state except WRITE. wr_addr/wr_data hold their last values when wr_en=0.
- frame_start sets swap_pend. When swap_pend=1 and state==IDLE, the next edge does three things: toggle rd_bank, clear col_count, clear swap_pend.
  - Pulse in IDLE: swap on the following edge; no ray is accepted in between.
  - Pulse mid-operation (or in the accept cycle): the current ray completes and is written to the old back bank. The swap follows on the first IDLE cycle.
  - A second pulse while swap_pend=1 is absorbed; one swap only.
- err clears only on Reset.
- Reset mid-DIV/WRITE aborts the operation: no partial write, and wr_en drops immediately (asynchronous).

Test Plan:
1. Reset, then ray col=5, dist=128, goal=0, color=3'b101 -> 18 cycles after accept: single-cycle wr_en, wr_addr=11'h405 (bank 1, col 5), wr_data=12'hA78; col_count=1.
2. dist=30 (quotient 512) -> wr_data[7:0]=8'hF0 (clamped). dist=0 -> write 2 cycles after accept, half=8'hF0. dist=16'hFFFF -> half=8'h00.
3. ray_col=700 -> no wr_en; err=1 and stays 1; next valid ray is accepted and written normally.
4. frame_start pulsed on cycle 5 of DIV -> write still targets bank 1; rd_bank becomes 1 the cycle after WRITE; col_count=0. Next ray writes bank 0; ray_ready is low during the swap cycle.
5. Back-to-back valid rays held high -> ray_ready low throughout processing; accepts spaced exactly 19 cycles. Two frame_start pulses during one ray -> exactly one rd_bank toggle.
6. Assert Reset during cycle 10 of DIV -> wr_en never asserts for that ray; all outputs return to their reset values.
